// File: rtl/dmem_io_arbiter.sv
// Two-port round-robin arbiter for the shared data-memory/IO path.
// Each grant runs a fixed-latency access, then a one-cycle acknowledge.
module dmem_io_arbiter #(
    parameter int MEM_LATENCY = 1,
    parameter int IO_BIT      = 7
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req0,
    input  logic        we0,
    input  logic [31:0] addr0,
    input  logic [31:0] wdata0,
    output logic        ack0,
    output logic [31:0] rdata0,
    input  logic        req1,
    input  logic        we1,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata1,
    output logic        ack1,
    output logic [31:0] rdata1,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        ram_we,
    output logic        io_we,
    input  logic [31:0] ram_rdata,
    input  logic [31:0] io_rdata,
    output logic        busy,
    output logic        grant_id
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [2:0] LAST_CNT = 3'(MEM_LATENCY - 1);

    state_t      state, state_nx;
    logic [2:0]  cnt;
    logic        last_grant;
    logic        latched_we;
    logic        win_vld;
    logic        win;
    logic        first_cyc;
    logic        last_cyc;
    logic [31:0] rd_sel;

    always_comb begin
        state_nx = state;
        win_vld  = 1'b0;
        win      = 1'b0;
        case (state)
            IDLE: begin
                // On a tie the pointer favours whoever did not win last time.
                if (req0 && req1) begin
                    win_vld = 1'b1;
                    win     = ~last_grant;
                end else if (req0 || req1) begin
                    win_vld = 1'b1;
                    win     = req1;
                end
                if (win_vld)
                    state_nx = ACCESS;
            end
            ACCESS: begin
                if (cnt == LAST_CNT)
                    state_nx = RESP;
            end
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    assign first_cyc = (state == ACCESS) && (cnt == 3'd0);
    assign last_cyc  = (state == ACCESS) && (cnt == LAST_CNT);
    assign rd_sel    = mem_addr[IO_BIT] ? io_rdata : ram_rdata;

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt        <= 3'd0;
            last_grant <= 1'b1;
            latched_we <= 1'b0;
            grant_id   <= 1'b0;
            mem_addr   <= 32'd0;
            mem_wdata  <= 32'd0;
            rdata0     <= 32'd0;
            rdata1     <= 32'd0;
        end else begin
            if (state == IDLE && win_vld) begin
                mem_addr   <= win ? addr1  : addr0;
                mem_wdata  <= win ? wdata1 : wdata0;
                latched_we <= win ? we1    : we0;
                grant_id   <= win;
                last_grant <= win;
                cnt        <= 3'd0;
            end else if (state == ACCESS) begin
                cnt <= cnt + 3'd1;
            end
            // Read data is sampled on the final access cycle only.
            if (last_cyc && !latched_we) begin
                if (grant_id)
                    rdata1 <= rd_sel;
                else
                    rdata0 <= rd_sel;
            end
        end
    end

    assign ram_we = first_cyc & latched_we & ~mem_addr[IO_BIT];
    assign io_we  = first_cyc & latched_we &  mem_addr[IO_BIT];
    assign ack0   = (state == RESP) & ~grant_id;
    assign ack1   = (state == RESP) &  grant_id;
    assign busy   = (state != IDLE);

endmodule

// File: tb/tb_dmem_io_arbiter.sv
// Bench for dmem_io_arbiter: two instances (latency 1 and 3) checked every cycle
// against a transaction-phase model, plus directed literal checks.
module tb_dmem_io_arbiter;

    localparam int IOB = 7;

    logic clock = 1'b0;
    logic reset = 1'b1;

    logic        r0[2], r1[2], w0[2], w1[2];
    logic        k0[2], k1[2], rwe[2], iwe[2], bsy[2], gid[2];
    logic [31:0] a0[2], a1[2], d0[2], d1[2], ramd[2], iod[2];
    logic [31:0] q0[2], q1[2], ma[2], mw[2];

    int vectors = 0;
    int miscompares = 0;

    // Model: a transaction is "in flight" for phases 1..L+1 after its grant edge;
    // phase 1 carries the strobe, phase L+1 carries the ack.
    bit          m_arm[2], m_in[2], m_win[2], m_we[2], m_last[2], m_gid[2];
    int          m_ph[2];
    logic [31:0] m_addr[2], m_wd[2], m_rd0[2], m_rd1[2];

    dmem_io_arbiter #(.MEM_LATENCY(1), .IO_BIT(IOB)) u_dut_l1 (
        .clock(clock), .reset(reset),
        .req0(r0[0]), .we0(w0[0]), .addr0(a0[0]), .wdata0(d0[0]), .ack0(k0[0]), .rdata0(q0[0]),
        .req1(r1[0]), .we1(w1[0]), .addr1(a1[0]), .wdata1(d1[0]), .ack1(k1[0]), .rdata1(q1[0]),
        .mem_addr(ma[0]), .mem_wdata(mw[0]), .ram_we(rwe[0]), .io_we(iwe[0]),
        .ram_rdata(ramd[0]), .io_rdata(iod[0]), .busy(bsy[0]), .grant_id(gid[0])
    );

    dmem_io_arbiter #(.MEM_LATENCY(3), .IO_BIT(IOB)) u_dut_l3 (
        .clock(clock), .reset(reset),
        .req0(r0[1]), .we0(w0[1]), .addr0(a0[1]), .wdata0(d0[1]), .ack0(k0[1]), .rdata0(q0[1]),
        .req1(r1[1]), .we1(w1[1]), .addr1(a1[1]), .wdata1(d1[1]), .ack1(k1[1]), .rdata1(q1[1]),
        .mem_addr(ma[1]), .mem_wdata(mw[1]), .ram_we(rwe[1]), .io_we(iwe[1]),
        .ram_rdata(ramd[1]), .io_rdata(iod[1]), .busy(bsy[1]), .grant_id(gid[1])
    );

    initial forever #5 clock = ~clock;

    function automatic int lat(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    task automatic chk1(input string nm, input int d, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s dut%0d: got %b want %b", nm, d, act, exp);
        end
    endtask

    task automatic chk32(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s dut%0d: got %h want %h", nm, d, act, exp);
        end
    endtask

    task automatic model_check(input int d);
        bit first, fin;
        first = m_in[d] && (m_ph[d] == 1);
        fin   = m_in[d] && (m_ph[d] == lat(d) + 1);
        chk1("busy", d, bsy[d], m_in[d]);
        chk1("ack0", d, k0[d], fin && !m_win[d]);
        chk1("ack1", d, k1[d], fin && m_win[d]);
        chk1("ram_we", d, rwe[d], first && m_we[d] && !m_addr[d][IOB]);
        chk1("io_we", d, iwe[d], first && m_we[d] && m_addr[d][IOB]);
        chk1("grant_id", d, gid[d], m_gid[d]);
        chk32("rdata0", d, q0[d], m_rd0[d]);
        chk32("rdata1", d, q1[d], m_rd1[d]);
        chk32("mem_addr", d, ma[d], m_addr[d]);
        chk32("mem_wdata", d, mw[d], m_wd[d]);
    endtask

    // Advance the model across the coming rising edge using the inputs it will sample.
    task automatic model_step(input int d);
        bit go, w;
        logic [31:0] v;
        if (reset) begin
            m_arm[d] = 1'b1; m_in[d] = 1'b0; m_last[d] = 1'b1; m_gid[d] = 1'b0;
            m_rd0[d] = '0; m_rd1[d] = '0; m_addr[d] = '0; m_wd[d] = '0;
            m_we[d] = 1'b0; m_win[d] = 1'b0; m_ph[d] = 0;
        end else if (m_in[d]) begin
            if (m_ph[d] == lat(d) && !m_we[d]) begin
                v = m_addr[d][IOB] ? iod[d] : ramd[d];
                if (m_win[d]) m_rd1[d] = v;
                else          m_rd0[d] = v;
            end
            if (m_ph[d] == lat(d) + 1) m_in[d] = 1'b0;
            else                       m_ph[d] = m_ph[d] + 1;
        end else begin
            go = r0[d] || r1[d];
            w  = (r0[d] && r1[d]) ? !m_last[d] : r1[d];
            if (go) begin
                m_in[d]   = 1'b1;
                m_ph[d]   = 1;
                m_win[d]  = w;
                m_gid[d]  = w;
                m_last[d] = w;
                m_we[d]   = w ? w1[d] : w0[d];
                m_addr[d] = w ? a1[d] : a0[d];
                m_wd[d]   = w ? d1[d] : d0[d];
            end
        end
    endtask

    task automatic tick();
        @(negedge clock);
        for (int d = 0; d < 2; d++) begin
            if (m_arm[d]) model_check(d);
            model_step(d);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic wait_ack(input int d, input int p, input int max);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < max && !seen; i++) begin
            tick();
            if ((p == 0) ? k0[d] : k1[d]) seen = 1'b1;
        end
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL wait_ack dut%0d port%0d: no ack within %0d cycles", d, p, max);
        end
    endtask

    initial begin
        int ack_p[$];
        int ack_t[$];
        int exp_t[4];
        int exp_p[4];
        exp_t = '{2, 5, 8, 11};
        exp_p = '{0, 1, 0, 1};
        for (int d = 0; d < 2; d++) begin
            r0[d] = 0; r1[d] = 0; w0[d] = 0; w1[d] = 0;
            a0[d] = '0; a1[d] = '0; d0[d] = '0; d1[d] = '0; ramd[d] = '0; iod[d] = '0;
        end
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        tick();
        chk1("rst_busy", 0, bsy[0], 1'b0);
        chk1("rst_grant", 0, gid[0], 1'b0);
        chk32("rst_rdata0", 0, q0[0], 32'h0);
        chk32("rst_mem_addr", 1, ma[1], 32'h0);

        // single RAM read on port 0
        a0[0] = 32'h10; ramd[0] = 32'hDEADBEEF; r0[0] = 1'b1;
        tick();
        chk1("t1_ack_early", 0, k0[0], 1'b0);
        tick();
        chk1("t1_ack0", 0, k0[0], 1'b1);
        chk32("t1_rdata0", 0, q0[0], 32'hDEADBEEF);
        chk32("t1_model_rd0", 0, m_rd0[0], 32'hDEADBEEF);
        r0[0] = 1'b0;
        tick();
        chk1("t1_ack_drop", 0, k0[0], 1'b0);

        // IO write on port 1
        r1[0] = 1'b1; w1[0] = 1'b1; a1[0] = 32'h84; d1[0] = 32'h5A;
        tick();
        chk1("t2_io_we", 0, iwe[0], 1'b1);
        chk1("t2_ram_we", 0, rwe[0], 1'b0);
        chk32("t2_mem_addr", 0, ma[0], 32'h84);
        chk32("t2_mem_wdata", 0, mw[0], 32'h5A);
        tick();
        chk1("t2_io_we_off", 0, iwe[0], 1'b0);
        chk1("t2_ack1", 0, k1[0], 1'b1);
        chk32("t2_rdata1", 0, q1[0], 32'h0);
        r1[0] = 1'b0; w1[0] = 1'b0;
        tick();

        // both requesting continuously from reset
        reset = 1'b1; tick(); reset = 1'b0; tick();
        a0[0] = 32'h20; a1[0] = 32'h24; ramd[0] = 32'h11112222;
        r0[0] = 1'b1; r1[0] = 1'b1;
        for (int i = 1; i <= 11; i++) begin
            tick();
            if (k0[0]) begin ack_p.push_back(0); ack_t.push_back(i); end
            if (k1[0]) begin ack_p.push_back(1); ack_t.push_back(i); end
        end
        r0[0] = 1'b0; r1[0] = 1'b0;
        tick(); tick();
        chk32("t3_nacks", 0, ack_p.size(), 32'd4);
        for (int j = 0; j < 4 && j < ack_p.size(); j++) begin
            chk32("t3_order", 0, ack_p[j], exp_p[j]);
            chk32("t3_ack_cycle", 0, ack_t[j], exp_t[j]);
        end

        // reset in the middle of a port-0 RAM write
        a0[0] = 32'h40; w0[0] = 1'b1; d0[0] = 32'h77; r0[0] = 1'b1;
        tick();
        chk1("t5_ram_we", 0, rwe[0], 1'b1);
        reset = 1'b1; r0[0] = 1'b0; w0[0] = 1'b0;
        tick();
        chk1("t5_ram_we_off", 0, rwe[0], 1'b0);
        chk1("t5_busy", 0, bsy[0], 1'b0);
        chk1("t5_no_ack", 0, k0[0], 1'b0);
        reset = 1'b0;
        tick();
        chk1("t5_no_late_ack", 0, k0[0], 1'b0);
        a0[0] = 32'h44; a1[0] = 32'h48; r0[0] = 1'b1; r1[0] = 1'b1;
        tick();
        chk1("t5_tie_grant", 0, gid[0], 1'b0);
        chk1("t5_busy_on", 0, bsy[0], 1'b1);
        wait_ack(0, 0, 4);
        r0[0] = 1'b0;
        wait_ack(0, 1, 6);
        r1[0] = 1'b0;
        tick();

        // port 1 drops req right after its grant
        ramd[0] = 32'hCAFEF00D; a1[0] = 32'h30; r1[0] = 1'b1;
        tick();
        chk1("t6_grant", 0, gid[0], 1'b1);
        r1[0] = 1'b0;
        tick();
        chk1("t6_ack1", 0, k1[0], 1'b1);
        chk32("t6_rdata1", 0, q1[0], 32'hCAFEF00D);
        tick();
        chk1("t6_idle", 0, bsy[0], 1'b0);
        tick();
        chk1("t6_no_reissue", 0, bsy[0], 1'b0);
        chk1("t6_ack1_off", 0, k1[0], 1'b0);

        // latency 3: IO read data changes before the final access cycle
        iod[1] = 32'h1234; a0[1] = 32'h80; r0[1] = 1'b1;
        tick();
        tick();
        iod[1] = 32'h9999;
        chk1("t4_ack_ph2", 1, k0[1], 1'b0);
        tick();
        chk1("t4_ack_ph3", 1, k0[1], 1'b0);
        chk32("t4_rdata_pre", 1, q0[1], 32'h0);
        tick();
        chk1("t4_ack0", 1, k0[1], 1'b1);
        chk32("t4_rdata0", 1, q0[1], 32'h9999);
        chk32("t4_model_rd0", 1, m_rd0[1], 32'h9999);
        r0[1] = 1'b0;
        tick();
        chk1("t4_ack_off", 1, k0[1], 1'b0);
        chk1("t4_idle", 1, bsy[1], 1'b0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
